// File: rtl/exec_controller_if.sv
// Command handshake and pipeline control bundle between the debug command
// decoder / pipeline top (master) and the execution controller (slave).
interface exec_controller_if #(
  parameter int unsigned CYCLE_COUNT_BITS = 32
);
  logic                        i_cmd_valid;
  logic [1:0]                  i_cmd;
  logic                        o_cmd_ready;
  logic                        i_halt;
  logic                        o_enable;
  logic                        o_flush;
  logic                        o_halted;
  logic                        o_step_done;
  logic [CYCLE_COUNT_BITS-1:0] o_cycle_count;

  modport master (
    output i_cmd_valid, i_cmd, i_halt,
    input  o_cmd_ready, o_enable, o_flush, o_halted, o_step_done, o_cycle_count
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt,
    output o_cmd_ready, o_enable, o_flush, o_halted, o_step_done, o_cycle_count
  );
endinterface

// File: rtl/exec_controller.sv
// Debug-unit execution sequencer: turns RUN/STEP/STOP/RESET_PIPE into pipeline
// enable/flush, tracks program halt and counts enabled cycles.
module exec_controller #(
  parameter int unsigned CYCLE_COUNT_BITS = 32,
  parameter int unsigned FLUSH_CYCLES     = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  exec_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUNNING, STEPPING, HALTED, FLUSHING} state_e;
  typedef enum logic [1:0] {CMD_RUN, CMD_STEP, CMD_STOP, CMD_RESET_PIPE} cmd_e;

  localparam logic [3:0]                  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CYCLE_COUNT_BITS-1:0] COUNT_ONE  = CYCLE_COUNT_BITS'(1);

  state_e     state;
  logic [3:0] flush_left;
  logic       cmd_fire;
  cmd_e       cmd;
  logic       enter_flush;

  assign cmd      = cmd_e'(bus.i_cmd);
  assign cmd_fire = bus.i_cmd_valid && bus.o_cmd_ready;

  // Ready is only high in IDLE/RUNNING/HALTED, so a fired RESET_PIPE always
  // flushes unless a halt in RUNNING takes priority on the same edge.
  always_comb begin
    enter_flush = cmd_fire && (cmd == CMD_RESET_PIPE) &&
                  !((state == RUNNING) && bus.i_halt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state             <= IDLE;
      flush_left        <= '0;
      bus.o_cmd_ready   <= 1'b1;
      bus.o_enable      <= 1'b0;
      bus.o_flush       <= 1'b0;
      bus.o_halted      <= 1'b0;
      bus.o_step_done   <= 1'b0;
      bus.o_cycle_count <= '0;
    end else begin
      bus.o_step_done <= 1'b0;
      if (bus.o_enable && (bus.o_cycle_count != '1))
        bus.o_cycle_count <= bus.o_cycle_count + COUNT_ONE;

      if (enter_flush) begin
        // Clearing here overrides the increment above on the entry edge.
        state             <= FLUSHING;
        flush_left        <= FLUSH_LOAD;
        bus.o_cmd_ready   <= 1'b0;
        bus.o_enable      <= 1'b0;
        bus.o_flush       <= 1'b1;
        bus.o_halted      <= 1'b0;
        bus.o_cycle_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_fire) begin
              case (cmd)
                CMD_RUN: begin
                  state        <= RUNNING;
                  bus.o_enable <= 1'b1;
                end
                CMD_STEP: begin
                  state           <= STEPPING;
                  bus.o_enable    <= 1'b1;
                  bus.o_cmd_ready <= 1'b0;
                end
                default: ;
              endcase
            end
          end
          RUNNING: begin
            if (bus.i_halt) begin
              state        <= HALTED;
              bus.o_enable <= 1'b0;
              bus.o_halted <= 1'b1;
            end else if (cmd_fire && (cmd == CMD_STOP)) begin
              state        <= IDLE;
              bus.o_enable <= 1'b0;
            end
          end
          STEPPING: begin
            bus.o_enable    <= 1'b0;
            bus.o_cmd_ready <= 1'b1;
            bus.o_step_done <= 1'b1;
            if (bus.i_halt) begin
              state        <= HALTED;
              bus.o_halted <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          HALTED: ;
          FLUSHING: begin
            if (flush_left == '0) begin
              state           <= IDLE;
              bus.o_flush     <= 1'b0;
              bus.o_cmd_ready <= 1'b1;
            end else begin
              flush_left <= flush_left - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed and randomized command
// sequences checked against a transaction-level expectation of the outputs.
module tb_exec_controller;

  localparam int unsigned FC         = 3;
  localparam int unsigned SMALL_BITS = 3;
  localparam logic [1:0]  C_RUN  = 2'b00;
  localparam logic [1:0]  C_STEP = 2'b01;
  localparam logic [1:0]  C_STOP = 2'b10;
  localparam logic [1:0]  C_RST  = 2'b11;

  logic   clk = 1'b0;
  logic   rst_n;
  int     checks   = 0;
  int     failures = 0;
  longint m_count  = 0;

  exec_controller_if #(.CYCLE_COUNT_BITS(32))         bus  ();
  exec_controller_if #(.CYCLE_COUNT_BITS(SMALL_BITS)) sbus ();

  exec_controller #(.CYCLE_COUNT_BITS(32), .FLUSH_CYCLES(FC)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  exec_controller #(.CYCLE_COUNT_BITS(SMALL_BITS), .FLUSH_CYCLES(1)) sdut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (sbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input bit en, input bit fl, input bit ha,
                             input bit sd, input bit rdy);
    chk({tag, ".enable"},    64'(bus.o_enable),      64'(en));
    chk({tag, ".flush"},     64'(bus.o_flush),       64'(fl));
    chk({tag, ".halted"},    64'(bus.o_halted),      64'(ha));
    chk({tag, ".step_done"}, 64'(bus.o_step_done),   64'(sd));
    chk({tag, ".ready"},     64'(bus.o_cmd_ready),   64'(rdy));
    chk({tag, ".count"},     64'(bus.o_cycle_count), 64'(m_count));
  endtask

  task automatic send(input logic [1:0] c, input string tag);
    chk({tag, ".ready"}, 64'(bus.o_cmd_ready), 64'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic do_flush();
    send(C_RST, "flush.cmd");
    m_count = 0;
    bus.i_halt = 1'b1;
    for (int unsigned i = 0; i < FC; i++) begin
      expect_outs("flush.active", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    bus.i_halt = 1'b0;
    expect_outs("flush.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // RUN, n further enabled cycles, then STOP: count grows by n + 1.
  task automatic do_run_stop(input int unsigned n);
    send(C_RUN, "run.cmd");
    expect_outs("run.first", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == n / 2) send(C_STEP, "run.ignored_step");
      else            tick();
      m_count++;
      expect_outs("run.body", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    send(C_STOP, "stop.cmd");
    m_count++;
    expect_outs("stop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_outs("stop.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_run_flush(input int unsigned n);
    send(C_RUN, "runf.cmd");
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      m_count++;
    end
    expect_outs("runf.body", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_flush();
  endtask

  task automatic do_step(input bit halt_mid);
    send(C_STEP, "step.cmd");
    expect_outs("step.pulse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.i_halt      = halt_mid;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = C_RST;
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_halt      = 1'b0;
    m_count++;
    expect_outs("step.done", 1'b0, 1'b0, halt_mid, 1'b1, 1'b1);
    tick();
    expect_outs("step.after", 1'b0, 1'b0, halt_mid, 1'b0, 1'b1);
    if (halt_mid) do_flush();
  endtask

  // Halt during RUN (or already high at RUN), commands ignored while halted, then flush.
  task automatic do_run_halt(input int unsigned n, input bit pre);
    if (pre) bus.i_halt = 1'b1;
    send(C_RUN, "halt.run");
    expect_outs("halt.first", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    if (!pre) begin
      for (int unsigned i = 0; i < n; i++) begin
        tick();
        m_count++;
      end
      bus.i_halt = 1'b1;
    end
    tick();
    m_count++;
    bus.i_halt = 1'b0;
    expect_outs("halt.enter", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(C_RUN, "halted.run");
    expect_outs("halted.after_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(C_STEP, "halted.step");
    expect_outs("halted.after_step", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(C_STOP, "halted.stop");
    tick();
    expect_outs("halted.after_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_flush();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = C_RUN;
    bus.i_halt       = 1'b0;
    sbus.i_cmd_valid = 1'b0;
    sbus.i_cmd       = C_RUN;
    sbus.i_halt      = 1'b0;

    repeat (3) tick();
    expect_outs("reset.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    expect_outs("reset.released", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send(C_STOP, "idle.stop");
    expect_outs("idle.stop_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    do_flush();

    do_run_stop(10);
    chk("run10.count_is_11", 64'(bus.o_cycle_count), 64'd11);
    do_run_stop($urandom_range(1, 20));

    do_flush();
    repeat (3) do_step(1'b0);
    chk("step3.count_is_3", 64'(bus.o_cycle_count), 64'd3);
    do_step(1'b1);

    do_run_halt(7, 1'b0);
    do_run_halt(0, 1'b1);

    // Reset mid-run and mid-flush.
    send(C_RUN, "rst.run_cmd");
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    m_count = 0;
    expect_outs("rst.mid_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    send(C_RST, "rst.flush_cmd");
    expect_outs("rst.flushing", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    expect_outs("rst.mid_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    expect_outs("rst.no_residual", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 4))
        0: do_run_stop($urandom_range(0, 15));
        1: do_step(1'($urandom_range(0, 1)));
        2: do_run_halt($urandom_range(0, 9), ($urandom_range(0, 3) == 0));
        3: do_flush();
        default: do_run_flush($urandom_range(0, 12));
      endcase
    end

    // Narrow counter saturates; single-cycle flush.
    sbus.i_cmd_valid = 1'b1;
    sbus.i_cmd       = C_RUN;
    tick();
    sbus.i_cmd_valid = 1'b0;
    chk("small.enable", 64'(sbus.o_enable), 64'd1);
    for (int unsigned i = 1; i <= 10; i++) begin
      tick();
      chk("small.count", 64'(sbus.o_cycle_count), 64'((i > 7) ? 7 : i));
    end
    sbus.i_cmd_valid = 1'b1;
    sbus.i_cmd       = C_RST;
    tick();
    sbus.i_cmd_valid = 1'b0;
    chk("small.flush_on", 64'(sbus.o_flush), 64'd1);
    chk("small.count_cleared", 64'(sbus.o_cycle_count), 64'd0);
    chk("small.enable_off", 64'(sbus.o_enable), 64'd0);
    tick();
    chk("small.flush_off", 64'(sbus.o_flush), 64'd0);
    chk("small.ready", 64'(sbus.o_cmd_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
